// File: rtl/hpu_regif_cfg_pc_reqack.sv
// AXI4-lite register bank: pseudo-channel base addresses plus req/ack handshake channels
// with per-channel timeout, sticky done/error bits and a registered interrupt.
module hpu_regif_cfg_pc_reqack #(
    parameter int PC_NB       = 16,
    parameter int PC_ADD_W    = 64,
    parameter int REQ_NB      = 2,
    parameter int TIMEOUT_W   = 16,
    parameter int AXIL_ADD_W  = 16,
    parameter int AXIL_DATA_W = 32
) (
    input  logic                              cfg_clk_i,
    input  logic                              cfg_srst_i,
    input  logic [AXIL_ADD_W-1:0]             s_axil_awaddr_i,
    input  logic                              s_axil_awvalid_i,
    output logic                              s_axil_awready_o,
    input  logic [AXIL_DATA_W-1:0]            s_axil_wdata_i,
    input  logic [AXIL_DATA_W/8-1:0]          s_axil_wstrb_i,
    input  logic                              s_axil_wvalid_i,
    output logic                              s_axil_wready_o,
    output logic [1:0]                        s_axil_bresp_o,
    output logic                              s_axil_bvalid_o,
    input  logic                              s_axil_bready_i,
    input  logic [AXIL_ADD_W-1:0]             s_axil_araddr_i,
    input  logic                              s_axil_arvalid_i,
    output logic                              s_axil_arready_o,
    output logic [AXIL_DATA_W-1:0]            s_axil_rdata_o,
    output logic [1:0]                        s_axil_rresp_o,
    output logic                              s_axil_rvalid_o,
    input  logic                              s_axil_rready_i,
    output logic [PC_NB-1:0][PC_ADD_W-1:0]    pc_addr_o,
    output logic [REQ_NB-1:0]                 req_o,
    input  logic [REQ_NB-1:0]                 ack_i,
    output logic                              irq_o
);

    if (PC_NB < 1 || PC_NB > 32) begin : g_chk_pc_nb
        $fatal(1, "PC_NB must be in 1..32");
    end
    if (PC_ADD_W < 1 || PC_ADD_W > 64) begin : g_chk_pc_add_w
        $fatal(1, "PC_ADD_W must be in 1..64");
    end
    if (REQ_NB < 1 || REQ_NB > 8) begin : g_chk_req_nb
        $fatal(1, "REQ_NB must be in 1..8");
    end
    if (TIMEOUT_W < 1 || TIMEOUT_W > 32) begin : g_chk_timeout_w
        $fatal(1, "TIMEOUT_W must be in 1..32");
    end
    if (AXIL_ADD_W < 10) begin : g_chk_add_w
        $fatal(1, "AXIL_ADD_W must be at least 10");
    end
    if (AXIL_DATA_W < 32 || (AXIL_DATA_W % 8) != 0) begin : g_chk_data_w
        $fatal(1, "AXIL_DATA_W must be a multiple of 8, at least 32");
    end

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReq     = 3'd1,
        StWaitLow = 3'd2
    } ch_state_e;

    typedef struct packed {
        logic       pc_hit;
        logic       ch_hit;
        logic [4:0] pc_idx;
        logic       msb;
        logic [2:0] ch_idx;
    } dec_t;

    // Decode a word address: PC registers first, channel block at byte 0x200.
    function automatic dec_t decode(input logic [31:0] wa);
        dec_t d;
        d = '0;
        if (wa < 32'(2 * PC_NB)) begin
            d.pc_hit = 1'b1;
            d.pc_idx = wa[5:1];
            d.msb    = wa[0];
        end else if (wa >= 32'h80 && wa < 32'h80 + 32'(REQ_NB)) begin
            d.ch_hit = 1'b1;
            d.ch_idx = wa[2:0];
        end
        return d;
    endfunction

    logic                        wr_hs, rd_hs;
    dec_t                        w_dec, r_dec;
    logic                        bvalid_q, rvalid_q, irq_q;
    logic [1:0]                  bresp_q, rresp_q, rresp_d;
    logic [AXIL_DATA_W-1:0]      rdata_q, rdata_d;
    logic [PC_NB-1:0][31:0]      pc_lsb_q, pc_msb_q;
    logic [REQ_NB-1:0][5:0]      ch_status;
    logic [REQ_NB-1:0]           ch_pend;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^{s_axil_awaddr_i[1:0], s_axil_araddr_i[1:0], s_axil_wstrb_i};

    assign w_dec = decode(32'(s_axil_awaddr_i[AXIL_ADD_W-1:2]));
    assign r_dec = decode(32'(s_axil_araddr_i[AXIL_ADD_W-1:2]));

    assign wr_hs = s_axil_awvalid_i & s_axil_wvalid_i & ~bvalid_q & ~cfg_srst_i;
    assign rd_hs = s_axil_arvalid_i & ~rvalid_q & ~cfg_srst_i;

    assign s_axil_awready_o = wr_hs;
    assign s_axil_wready_o  = wr_hs;
    assign s_axil_arready_o = rd_hs;
    assign s_axil_bvalid_o  = bvalid_q;
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_rvalid_o  = rvalid_q;
    assign s_axil_rresp_o   = rresp_q;
    assign s_axil_rdata_o   = rdata_q;
    assign irq_o            = irq_q;

    always_ff @(posedge cfg_clk_i) begin
        if (cfg_srst_i) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RespOkay;
        end else if (wr_hs) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (w_dec.pc_hit | w_dec.ch_hit) ? RespOkay : RespSlverr;
        end else if (s_axil_bready_i) begin
            bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge cfg_clk_i) begin
        if (cfg_srst_i) begin
            pc_lsb_q <= '0;
            pc_msb_q <= '0;
        end else if (wr_hs && w_dec.pc_hit) begin
            for (int i = 0; i < PC_NB; i++) begin
                if (w_dec.pc_idx == 5'(i)) begin
                    if (w_dec.msb) pc_msb_q[i] <= s_axil_wdata_i[31:0];
                    else           pc_lsb_q[i] <= s_axil_wdata_i[31:0];
                end
            end
        end
    end

    for (genvar i = 0; i < PC_NB; i++) begin : g_pc
        assign pc_addr_o[i] = PC_ADD_W'({pc_msb_q[i], pc_lsb_q[i]});
    end

    for (genvar g = 0; g < REQ_NB; g++) begin : g_ch
        ch_state_e            state_q;
        logic                 req_q, done_q, err_q;
        logic [TIMEOUT_W-1:0] cnt_q, cnt_inc;
        logic                 ctl_wr, tmo, set_done, set_err;

        assign ctl_wr   = wr_hs & w_dec.ch_hit & (w_dec.ch_idx == 3'(g));
        assign cnt_inc  = cnt_q + TIMEOUT_W'(1);
        assign tmo      = (cnt_inc == {TIMEOUT_W{1'b1}});
        assign set_done = (state_q == StWaitLow) & ~ack_i[g];
        // Timeout only fires when the handshake is not already advancing this cycle.
        assign set_err  = tmo & (((state_q == StReq) & ~ack_i[g]) |
                                 ((state_q == StWaitLow) & ack_i[g]));

        always_ff @(posedge cfg_clk_i) begin
            if (cfg_srst_i) begin
                state_q <= StIdle;
                req_q   <= 1'b0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                done_q <= (done_q & ~(ctl_wr & s_axil_wdata_i[1])) | set_done;
                err_q  <= (err_q & ~(ctl_wr & s_axil_wdata_i[2])) | set_err;
                case (state_q)
                    StIdle: begin
                        if (ctl_wr && s_axil_wdata_i[0]) begin
                            state_q <= StReq;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    StReq: begin
                        cnt_q <= cnt_inc;
                        if (ack_i[g]) begin
                            state_q <= StWaitLow;
                            req_q   <= 1'b0;
                        end else if (tmo) begin
                            state_q <= StIdle;
                            req_q   <= 1'b0;
                        end
                    end
                    StWaitLow: begin
                        cnt_q <= cnt_inc;
                        if (!ack_i[g] || tmo) state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign req_o[g]     = req_q;
        assign ch_pend[g]   = done_q | err_q;
        assign ch_status[g] = {state_q, err_q, done_q, state_q != StIdle};
    end

    always_ff @(posedge cfg_clk_i) begin
        if (cfg_srst_i) irq_q <= 1'b0;
        else            irq_q <= |ch_pend;
    end

    always_comb begin
        rdata_d = '0;
        rresp_d = RespSlverr;
        if (r_dec.pc_hit) begin
            rresp_d = RespOkay;
            for (int i = 0; i < PC_NB; i++) begin
                if (r_dec.pc_idx == 5'(i)) begin
                    rdata_d = AXIL_DATA_W'(r_dec.msb ? pc_msb_q[i] : pc_lsb_q[i]);
                end
            end
        end else if (r_dec.ch_hit) begin
            rresp_d = RespOkay;
            for (int j = 0; j < REQ_NB; j++) begin
                if (r_dec.ch_idx == 3'(j)) rdata_d = AXIL_DATA_W'(ch_status[j]);
            end
        end
    end

    always_ff @(posedge cfg_clk_i) begin
        if (cfg_srst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
        end else if (rd_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end else if (s_axil_rready_i) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hpu_regif_cfg_pc_reqack.sv
// Self-checking bench for hpu_regif_cfg_pc_reqack: register map, req/ack channels,
// timeout, sticky bits, interrupt and reset behaviour against a behavioural model.
module tb_hpu_regif_cfg_pc_reqack;
    localparam int PcNb     = 16;
    localparam int PcAddW   = 40;
    localparam int ReqNb    = 2;
    localparam int ToW      = 4;
    localparam int ToCycles = (1 << ToW) - 1;

    logic                   clk, srst;
    logic [15:0]            awaddr, araddr;
    logic [31:0]            wdata, rdata;
    logic [3:0]             wstrb;
    logic                   awvalid, awready, wvalid, wready, bvalid, bready;
    logic                   arvalid, arready, rvalid, rready;
    logic [1:0]             bresp, rresp;
    logic [PcNb-1:0][PcAddW-1:0] pc_addr;
    logic [ReqNb-1:0]       req, ack;
    logic                   irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_lsb [PcNb];
    logic [31:0] m_msb [PcNb];

    hpu_regif_cfg_pc_reqack #(
        .PC_NB(PcNb), .PC_ADD_W(PcAddW), .REQ_NB(ReqNb), .TIMEOUT_W(ToW),
        .AXIL_ADD_W(16), .AXIL_DATA_W(32)
    ) dut (
        .cfg_clk_i(clk), .cfg_srst_i(srst),
        .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
        .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
        .s_axil_rready_i(rready),
        .pc_addr_o(pc_addr), .req_o(req), .ack_i(ack), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        #1;
        while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL aw_handshake addr=%h: awready/wready not seen within 20 cycles", a);
        end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL b_timeout addr=%h: bvalid=%b required 1 within 20 cycles", a, bvalid);
        end
        resp = bresp;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        #1;
        while (arready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL ar_handshake addr=%h: arready not seen within 20 cycles", a);
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL r_timeout addr=%h: rvalid=%b required 1 within 20 cycles", a, rvalid);
        end
        d = rdata; resp = rresp;
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
    endtask

    // Raise ack after req has been seen high on d clock cycles, drop it l cycles later.
    task automatic responder(input int ch, input int d, input int l, output int hi);
        int n;
        hi = 0; n = 0;
        while (req[ch] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL req_rise ch%0d: req=%b required 1 within 40 cycles", ch, req[ch]);
            return;
        end
        n = 0;
        while (n < 40) begin
            if (req[ch] === 1'b1) hi++;
            if (hi >= d) break;
            @(negedge clk);
            n++;
        end
        ack[ch] = 1'b1;
        for (int k = 0; k < l; k++) begin
            @(negedge clk);
            if (req[ch] === 1'b1) hi++;
        end
        ack[ch] = 1'b0;
    endtask

    task automatic measure_high(input int ch, output int hi);
        int n;
        hi = 0; n = 0;
        while (req[ch] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        while (req[ch] === 1'b1 && hi < 60) begin hi++; @(negedge clk); end
    endtask

    task automatic check_pc_all(input string tag);
        logic [63:0] full;
        for (int i = 0; i < PcNb; i++) begin
            full = {m_msb[i], m_lsb[i]};
            checks++;
            if (pc_addr[i] !== full[PcAddW-1:0]) begin
                errors++;
                $display("FAIL %s pc_addr[%0d]: got %h required %h", tag, i, pc_addr[i],
                         full[PcAddW-1:0]);
            end
        end
    endtask

    task automatic test_reset();
        srst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        awaddr = 16'h0; araddr = 16'h0; wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_axi: aw/w/ar/b/r=%b required 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if (req !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_chan: req=%b irq=%b required 0/0", req, irq);
        end
        checks++;
        if (pc_addr !== '0) begin
            errors++;
            $display("FAIL reset_pc: pc_addr nonzero %h", pc_addr);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < PcNb; i++) begin m_lsb[i] = '0; m_msb[i] = '0; end
    endtask

    task automatic test_pc_regs();
        logic [1:0]  resp, exp_resp;
        logic [31:0] d, exp_d;
        logic [15:0] a;
        int          i;
        logic        msb;
        axi_write(16'h018, 32'hDEAD_BEEF, resp); m_lsb[3] = 32'hDEAD_BEEF;
        axi_write(16'h01C, 32'h0000_0012, resp); m_msb[3] = 32'h0000_0012;
        checks++;
        if (pc_addr[3] !== 40'h12_DEAD_BEEF) begin
            errors++;
            $display("FAIL pc3_directed: got %h required 12deadbeef", pc_addr[3]);
        end
        axi_read(16'h01C, d, resp);
        checks++;
        if (d !== 32'h12 || resp !== 2'b00) begin
            errors++;
            $display("FAIL pc3_msb_read: data=%h resp=%b required 00000012/00", d, resp);
        end
        for (int k = 0; k < 24; k++) begin
            d = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                i = $urandom_range(0, PcNb - 1);
                msb = 1'($urandom_range(0, 1));
                a = 16'(8 * i + (msb ? 4 : 0));
                exp_resp = 2'b00;
                if (msb) m_msb[i] = d; else m_lsb[i] = d;
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 16'h080 + 16'(4 * $urandom_range(0, 95));
                    1:       a = 16'h300;
                    2:       a = 16'h208 + 16'(4 * $urandom_range(0, 5));
                    default: a = 16'h1000;
                endcase
                exp_resp = 2'b10;
            end
            axi_write(a, d, resp);
            checks++;
            if (resp !== exp_resp) begin
                errors++;
                $display("FAIL rand_bresp addr=%h: got %b required %b", a, resp, exp_resp);
            end
            check_pc_all("rand_write");
        end
        for (int k = 0; k < 10; k++) begin
            i = $urandom_range(0, PcNb - 1);
            msb = 1'($urandom_range(0, 1));
            exp_d = msb ? m_msb[i] : m_lsb[i];
            axi_read(16'(8 * i + (msb ? 4 : 0)), d, resp);
            checks++;
            if (d !== exp_d || resp !== 2'b00) begin
                errors++;
                $display("FAIL rand_read pc%0d msb=%b: data=%h resp=%b required %h/00",
                         i, msb, d, resp, exp_d);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [1:0]  resp;
        logic [31:0] d;
        axi_write(16'h300, 32'hFFFF_FFFF, resp);
        checks++;
        if (resp !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_wr 0x300: bresp=%b required 10", resp);
        end
        axi_read(16'h1FC, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_rd 0x1FC: data=%h resp=%b required 0/10", d, resp);
        end
        axi_read(16'h208, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10) begin
            errors++;
            $display("FAIL unmapped_rd 0x208: data=%h resp=%b required 0/10", d, resp);
        end
        check_pc_all("unmapped");
        axi_read(16'h200, d, resp);
        checks++;
        if (d !== 32'h0 || req !== '0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_chan: status=%h req=%b irq=%b required 0", d, req, irq);
        end
    endtask

    task automatic test_handshake();
        logic [1:0]  resp;
        logic [31:0] d;
        int          ch, dl, ll, hi;
        logic [15:0] a;
        for (int it = 0; it < 6; it++) begin
            ch = $urandom_range(0, ReqNb - 1);
            dl = (it == 0) ? 5 : $urandom_range(1, 6);
            ll = (it == 0) ? 3 : $urandom_range(1, 6);
            a  = 16'h200 + 16'(4 * ch);
            fork
                responder(ch, dl, ll, hi);
                axi_write(a, 32'h1, resp);
            join
            checks++;
            if (hi !== dl) begin
                errors++;
                $display("FAIL req_width ch%0d: req high %0d cycles required %0d", ch, hi, dl);
            end
            @(negedge clk);
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL irq_delay ch%0d: irq=%b required 0 one cycle after done", ch, irq);
            end
            @(negedge clk);
            checks++;
            if (irq !== 1'b1) begin
                errors++;
                $display("FAIL irq_set ch%0d: irq=%b required 1", ch, irq);
            end
            axi_read(a, d, resp);
            checks++;
            if (d !== 32'h2 || resp !== 2'b00) begin
                errors++;
                $display("FAIL done_status ch%0d: data=%h resp=%b required 2/00", ch, d, resp);
            end
            axi_write(a, 32'h2, resp);
            axi_read(a, d, resp);
            checks++;
            if (d !== 32'h0 || irq !== 1'b0) begin
                errors++;
                $display("FAIL done_clear ch%0d: status=%h irq=%b required 0/0", ch, d, irq);
            end
        end
    endtask

    task automatic test_zero_wait();
        logic [1:0]  resp;
        logic [31:0] d;
        int          hi;
        ack[0] = 1'b1;
        fork
            responder(0, 1, 2, hi);
            axi_write(16'h200, 32'h1, resp);
        join
        checks++;
        if (hi !== 1) begin
            errors++;
            $display("FAIL zero_wait: req high %0d cycles required 1", hi);
        end
        repeat (2) @(negedge clk);
        axi_read(16'h200, d, resp);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL zero_wait_status: got %h required 2", d);
        end
        axi_write(16'h200, 32'h2, resp);
    endtask

    task automatic test_busy_start();
        logic [1:0]  r1, r2, resp;
        logic [31:0] d, sd;
        int          hi;
        fork
            responder(1, 10, 3, hi);
            begin
                axi_write(16'h204, 32'h1, r1);
                axi_read(16'h204, sd, resp);
                axi_write(16'h204, 32'h1, r2);
            end
        join
        checks++;
        if (sd !== 32'h9) begin
            errors++;
            $display("FAIL busy_status: got %h required 9 (busy, REQ)", sd);
        end
        checks++;
        if (r2 !== 2'b00) begin
            errors++;
            $display("FAIL busy_start_bresp: got %b required 00", r2);
        end
        checks++;
        if (hi !== 10) begin
            errors++;
            $display("FAIL busy_start_width: req high %0d cycles required 10", hi);
        end
        repeat (2) @(negedge clk);
        axi_read(16'h204, d, resp);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL busy_done_status: got %h required 2", d);
        end
        axi_write(16'h204, 32'h2, resp);
    endtask

    task automatic test_timeout();
        logic [1:0]  resp;
        logic [31:0] d;
        int          hi;
        ack = '0;
        fork
            measure_high(0, hi);
            axi_write(16'h200, 32'h1, resp);
        join
        checks++;
        if (hi !== ToCycles) begin
            errors++;
            $display("FAIL timeout_width: req high %0d cycles required %0d", hi, ToCycles);
        end
        axi_read(16'h200, d, resp);
        checks++;
        if (d !== 32'h4 || irq !== 1'b1) begin
            errors++;
            $display("FAIL timeout_status: status=%h irq=%b required 4/1", d, irq);
        end
        // Clear of the error lands on the same edge as the timeout on channel 1.
        axi_write(16'h204, 32'h1, resp);
        hi = 2;
        checks++;
        if (req[1] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins_setup: req[1]=%b required 1", req[1]);
        end
        while (hi < ToCycles) begin
            @(negedge clk);
            if (req[1] === 1'b1) hi++;
            else break;
        end
        axi_write(16'h204, 32'h4, resp);
        axi_read(16'h204, d, resp);
        checks++;
        if (d !== 32'h4 || req[1] !== 1'b0) begin
            errors++;
            $display("FAIL set_wins: status=%h req=%b required 4/0", d, req[1]);
        end
        axi_write(16'h200, 32'h5, resp);
        axi_read(16'h200, d, resp);
        checks++;
        if (d !== 32'h9) begin
            errors++;
            $display("FAIL start_and_clear: status=%h required 9", d);
        end
        repeat (20) @(negedge clk);
        axi_read(16'h200, d, resp);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL timeout_again: status=%h required 4", d);
        end
        axi_write(16'h200, 32'h4, resp);
        axi_write(16'h204, 32'h4, resp);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL timeout_irq_clear: irq=%b required 0", irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]  resp;
        logic [31:0] d;
        ack = '0;
        axi_write(16'h200, 32'h1, resp);
        awaddr = 16'h000; wdata = 32'hA5A5_A5A5; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || req[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: bvalid=%b req0=%b required 1/1", bvalid, req[0]);
        end
        srst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < PcNb; i++) begin m_lsb[i] = '0; m_msb[i] = '0; end
        checks++;
        if (req !== '0 || bvalid !== 1'b0 || irq !== 1'b0 || pc_addr !== '0) begin
            errors++;
            $display("FAIL reset_mid: req=%b bvalid=%b irq=%b pc0=%h required all 0",
                     req, bvalid, irq, pc_addr[0]);
        end
        srst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_noresp: bvalid=%b required 0", bvalid);
        end
        axi_read(16'h200, d, resp);
        checks++;
        if (d !== 32'h0 || resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_status: data=%h resp=%b required 0/00", d, resp);
        end
        check_pc_all("reset_mid");
    endtask

    initial begin
        srst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        ack = '0;
        test_reset();
        test_pc_regs();
        test_unmapped();
        test_handshake();
        test_zero_wait();
        test_busy_start();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
